clock_div_multi: RTL and testbench

CLOCK_DIV_MULTI -- requirements
Module: clock_div_multi

---
 rtl/clock_div_multi.sv | 134 +++++++++++++
 tb/tb_clock_div_multi.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_multi.sv
// ---------------------------------------------------------------------------
// clock_div_multi
//
// Purpose:
//   NUM_CH independent clock dividers running off one system clock. Each
//   channel owns a synchronous WIDTH-bit counter; its divided clock and tick
//   are registered outputs, never used as clocks inside this block. Divisors
//   are changed through a valid/ready port into a per-channel shadow
//   register. The shadow value becomes active at the channel's next period
//   boundary, so a running period is never cut short by an update.
//
// Ports:
//   clock      in   system clock, all state updates on its rising edge
//   reset      in   asynchronous, active-high reset
//   enable     in   [NUM_CH]  per-channel run enable
//   cfg_valid  in   divisor update request
//   cfg_ch     in   [CH_W]    target channel of the update
//   cfg_div    in   [WIDTH]   new divisor (0 and 1 behave as 2)
//   cfg_ready  out  low while the addressed channel still holds a pending update
//   div_clock  out  [NUM_CH]  divided clock, high for floor(D/2) of D cycles
//   tick       out  [NUM_CH]  one-cycle pulse in the first high cycle of div_clock
//   sync       in   (only with CLOCK_DIV_MULTI_SYNC_EN) restarts every running
//                   channel so that all phases line up
//
// Optional feature macro: CLOCK_DIV_MULTI_SYNC_EN
// ---------------------------------------------------------------------------
module clock_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 17,
    parameter int DEFAULT_DIV = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
`ifdef CLOCK_DIV_MULTI_SYNC_EN
    input  logic              sync,
`endif
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] div_clock,
    output logic [NUM_CH-1:0] tick
);

    // Stored divisors of 0 or 1 run as 2.
    function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    logic [NUM_CH-1:0] pending;

    // Ready only depends on the addressed channel; an index that matches no
    // channel leaves ready high and the update falls through unused.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((cfg_ch == i[CH_W-1:0]) && pending[i]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] act_div;
        logic [WIDTH-1:0] shadow;
        logic             pend_r;
        logic             run_r;
        logic             dclk_r;
        logic             tick_r;

        logic [WIDTH-1:0] d_cur;
        logic [WIDTH-1:0] d_nxt;
        logic [WIDTH-1:0] cnt_nxt;
        logic             wrap;
        logic             restart;
        logic             apply;
        logic             accept;

`ifdef CLOCK_DIV_MULTI_SYNC_EN
        assign restart = enable[i] && (!run_r || sync);
`else
        assign restart = enable[i] && !run_r;
`endif
        assign accept = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

        always_comb begin
            d_cur = eff_div(act_div);
            wrap  = run_r && (cnt == d_cur - WIDTH'(1));
            // A pending divisor lands whenever a new period begins or the
            // channel is (or is becoming) idle.
            apply = pend_r && (!run_r || !enable[i] || wrap || restart);
            d_nxt = apply ? eff_div(shadow) : d_cur;
            if (!enable[i] || restart || wrap) begin
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + WIDTH'(1);
            end
        end

        // Outputs are derived from the next counter value and the divisor
        // that will govern it, so they line up with the counter cycle by cycle.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt     <= '0;
                act_div <= WIDTH'(DEFAULT_DIV);
                shadow  <= WIDTH'(DEFAULT_DIV);
                pend_r  <= 1'b0;
                run_r   <= 1'b0;
                dclk_r  <= 1'b0;
                tick_r  <= 1'b0;
            end else begin
                run_r  <= enable[i];
                cnt    <= cnt_nxt;
                dclk_r <= enable[i] && (cnt_nxt < (d_nxt >> 1));
                tick_r <= enable[i] && (cnt_nxt == '0);
                if (apply) begin
                    act_div <= shadow;
                    pend_r  <= 1'b0;
                end else if (accept) begin
                    shadow <= cfg_div;
                    pend_r <= 1'b1;
                end
            end
        end

        assign pending[i]   = pend_r;
        assign div_clock[i] = dclk_r;
        assign tick[i]      = tick_r;
    end

endmodule

// File: tb/tb_clock_div_multi.sv
module tb_clock_div_multi;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  enable;
    logic        cfg_valid;
    logic [1:0]  cfg_ch;
    logic [16:0] cfg_div;
    logic        sync;
    logic        cfg_ready;
    logic [3:0]  div_clock;
    logic [3:0]  tick;

    // Three-channel instance: cfg_ch = 3 is a representable, out-of-range index.
    logic [2:0]  b_enable;
    logic        b_cfg_valid;
    logic [1:0]  b_cfg_ch;
    logic [16:0] b_cfg_div;
    logic        b_sync;
    logic        b_cfg_ready;
    logic [2:0]  b_div_clock;
    logic [2:0]  b_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, one entry per channel.
    bit m_run  [4];
    int m_pos  [4];
    int m_d    [4];
    int m_sh   [4];
    bit m_pend [4];

    always #5 clock = ~clock;

    clock_div_multi #(.NUM_CH(4), .WIDTH(17), .DEFAULT_DIV(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
`ifdef CLOCK_DIV_MULTI_SYNC_EN
        .sync      (sync),
`endif
        .cfg_ready (cfg_ready),
        .div_clock (div_clock),
        .tick      (tick)
    );

    clock_div_multi #(.NUM_CH(3), .WIDTH(17), .DEFAULT_DIV(4)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .enable    (b_enable),
        .cfg_valid (b_cfg_valid),
        .cfg_ch    (b_cfg_ch),
        .cfg_div   (b_cfg_div),
`ifdef CLOCK_DIV_MULTI_SYNC_EN
        .sync      (b_sync),
`endif
        .cfg_ready (b_cfg_ready),
        .div_clock (b_div_clock),
        .tick      (b_tick)
    );

    function automatic int eff(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0; m_pos[i] = 0; m_d[i] = 4; m_sh[i] = 4; m_pend[i] = 0;
        end
    endtask

    // One rising edge of the behavioural model, using the inputs held across it.
    task automatic model_edge();
        bit acc;
        int c;
        c   = int'(cfg_ch);
        acc = cfg_valid && !m_pend[c];
        for (int i = 0; i < 4; i++) begin
            bit ap;
            ap = 0;
            if (!enable[i]) begin
                ap = m_pend[i]; m_run[i] = 0; m_pos[i] = 0;
            end else if (!m_run[i] || sync === 1'b1) begin
                ap = m_pend[i]; m_run[i] = 1; m_pos[i] = 0;
            end else begin
                m_pos[i]++;
                if (m_pos[i] >= eff(m_d[i])) begin
                    m_pos[i] = 0; ap = m_pend[i];
                end
            end
            if (ap) begin m_d[i] = m_sh[i]; m_pend[i] = 0; end
        end
        if (acc) begin m_sh[c] = int'(cfg_div); m_pend[c] = 1; end
    endtask

    function automatic logic [3:0] exp_div();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_run[i] && (m_pos[i] < eff(m_d[i]) / 2);
        return v;
    endfunction

    function automatic logic [3:0] exp_tick();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_run[i] && (m_pos[i] == 0);
        return v;
    endfunction

    // Advance one clock; returns at the following falling edge.
    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = '0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0; sync = 0;
        b_enable = '0; b_cfg_valid = 0; b_cfg_ch = 0; b_cfg_div = 0; b_sync = 0;
        model_reset();
        repeat (3) @(negedge clock);
        for (int c = 0; c < 4; c++) begin
            cfg_ch = 2'(c);
            #1;
            n_checks++;
            if (div_clock !== 4'b0 || tick !== 4'b0 || cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_state ch%0d: div_clock=%b tick=%b cfg_ready=%b, required 0000 0000 1",
                         c, div_clock, tick, cfg_ready);
            end
        end
        cfg_ch = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_default_pattern();
        enable = 4'b0001;
        for (int n = 0; n < 12; n++) begin
            cycle();
            n_checks++;
            if (div_clock[0] !== ((n % 4) < 2) || tick[0] !== (n % 4 == 0)) begin
                n_fail++;
                $display("FAIL default_pattern n=%0d: div=%b tick=%b, required %b %b",
                         n, div_clock[0], tick[0], (n % 4) < 2, n % 4 == 0);
            end
        end
    endtask

    task automatic test_update_midperiod();
        cfg_valid = 1; cfg_ch = 1; cfg_div = 5;
        cycle();
        cfg_valid = 0;
        cycle();
        enable[1] = 1'b1;
        for (int n = 0; n < 14; n++) begin
            bit ed, et, er;
            cycle();
            cfg_valid = 0;
            if (n == 1) begin cfg_valid = 1; cfg_ch = 1; cfg_div = 3; end
            #1;
            ed = (n < 5) ? (n < 2) : (((n - 5) % 3) < 1);
            et = (n == 0) || (n >= 5 && ((n - 5) % 3) == 0);
            er = !(n >= 2 && n <= 4);
            n_checks++;
            if (div_clock[1] !== ed || tick[1] !== et || cfg_ready !== er) begin
                n_fail++;
                $display("FAIL update_midperiod n=%0d: div=%b tick=%b ready=%b, required %b %b %b",
                         n, div_clock[1], tick[1], cfg_ready, ed, et, er);
            end
        end
        cfg_valid = 0;
    endtask

    task automatic test_div_zero_one();
        cfg_valid = 1; cfg_ch = 2; cfg_div = 0;
        cycle();
        cfg_valid = 0;
        cycle();
        enable[2] = 1'b1;
        for (int n = 0; n < 8; n++) begin
            cycle();
            cfg_valid = 0;
            if (n == 2) begin cfg_valid = 1; cfg_ch = 2; cfg_div = 1; end
            n_checks++;
            if (div_clock[2] !== (n % 2 == 0) || tick[2] !== (n % 2 == 0)) begin
                n_fail++;
                $display("FAIL div_zero_one n=%0d: div=%b tick=%b, required %b %b",
                         n, div_clock[2], tick[2], n % 2 == 0, n % 2 == 0);
            end
        end
        cfg_valid = 0;
    endtask

    task automatic test_async_reset();
        cfg_valid = 1; cfg_ch = 3; cfg_div = 6;
        cycle();
        cfg_valid = 0;
        cycle();
        enable[3] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cycle();
            cfg_valid = 0;
            if (n == 1) begin cfg_valid = 1; cfg_ch = 0; cfg_div = 9; end
        end
        n_checks++;
        if (div_clock[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_high: div=%b, required 1", div_clock[3]);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (div_clock !== 4'b0 || tick !== 4'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: div_clock=%b tick=%b ready=%b, required 0000 0000 1",
                     div_clock, tick, cfg_ready);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int n = 0; n < 8; n++) begin
            cycle();
            n_checks++;
            if (div_clock !== {4{(n % 4) < 2}} || tick !== {4{n % 4 == 0}}) begin
                n_fail++;
                $display("FAIL after_reset n=%0d: div_clock=%b tick=%b, required %b %b",
                         n, div_clock, tick, {4{(n % 4) < 2}}, {4{n % 4 == 0}});
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 15) == 0) enable[i] = ~enable[i];
            cfg_valid = ($urandom_range(0, 9) < 3);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = 17'($urandom_range(0, 9));
            #1;
            n_checks++;
            if (cfg_ready !== !m_pend[cfg_ch]) begin
                n_fail++;
                $display("FAIL random_ready n=%0d ch%0d: ready=%b, required %b",
                         n, cfg_ch, cfg_ready, !m_pend[cfg_ch]);
            end
            cycle();
            n_checks++;
            if (div_clock !== exp_div() || tick !== exp_tick()) begin
                n_fail++;
                $display("FAIL random_outputs n=%0d: div_clock=%b tick=%b, required %b %b",
                         n, div_clock, tick, exp_div(), exp_tick());
            end
        end
        cfg_valid = 0;
    endtask

    task automatic test_out_of_range();
        b_cfg_valid = 1; b_cfg_ch = 2'd3; b_cfg_div = 17'd2;
        #1;
        n_checks++;
        if (b_cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_ready: ready=%b, required 1", b_cfg_ready);
        end
        b_enable = 3'b111;
        for (int n = 0; n < 12; n++) begin
            @(posedge clock);
            @(negedge clock);
            b_cfg_div = 17'($urandom_range(0, 9));
            n_checks++;
            if (b_div_clock !== {3{(n % 4) < 2}} || b_tick !== {3{n % 4 == 0}} || b_cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL oob_no_effect n=%0d: div=%b tick=%b ready=%b, required %b %b 1",
                         n, b_div_clock, b_tick, b_cfg_ready, {3{(n % 4) < 2}}, {3{n % 4 == 0}});
            end
        end
        b_cfg_valid = 0;
        for (int c = 0; c < 3; c++) begin
            b_cfg_ch = 2'(c);
            #1;
            n_checks++;
            if (b_cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL oob_no_pending ch%0d: ready=%b, required 1", c, b_cfg_ready);
            end
        end
    endtask

`ifdef CLOCK_DIV_MULTI_SYNC_EN
    task automatic test_sync();
        enable = 4'b0000;
        cfg_valid = 1; cfg_ch = 0; cfg_div = 4;
        cycle();
        cfg_ch = 1; cfg_div = 6;
        cycle();
        cfg_valid = 0;
        cycle();
        enable[0] = 1'b1;
        cycle();
        cycle();
        enable[1] = 1'b1;
        repeat (3) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        n_checks++;
        if (tick[1:0] !== 2'b11 || div_clock[1:0] !== 2'b11 || tick !== exp_tick()) begin
            n_fail++;
            $display("FAIL sync_align: tick=%b div=%b, required tick[1:0]=11 div[1:0]=11",
                     tick, div_clock);
        end
        for (int n = 0; n < 12; n++) begin
            cycle();
            n_checks++;
            if (div_clock !== exp_div() || tick !== exp_tick()) begin
                n_fail++;
                $display("FAIL sync_after n=%0d: div=%b tick=%b, required %b %b",
                         n, div_clock, tick, exp_div(), exp_tick());
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default_pattern();
        test_update_midperiod();
        test_div_zero_one();
        test_async_reset();
        test_random();
        test_out_of_range();
`ifdef CLOCK_DIV_MULTI_SYNC_EN
        test_sync();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
